// File: rtl/spi_proto_defs.sv
// Shared SPI device protocol definitions.
//   - Command bytes understood by the device.
//   - FSM state encoding for the TX buffer read engine.
//   - sat_byte(): clamps a count to one byte for reporting over MISO.
package spi_proto_defs;

  localparam logic [7:0] CmdButtonState = 8'hF4;
  localparam logic [7:0] CmdReadTxBuf   = 8'hF5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCmd    = 2'd1,
    StStream = 2'd2,
    StIgnore = 2'd3
  } spi_state_e;

  function automatic logic [7:0] sat_byte(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/spi_dev_txbuf_if.sv
// Bus bundle for spi_dev_txbuf.
//   Core side : usr_mosi_data/usr_mosi_stb (rx byte), usr_miso_data/usr_miso_ack (tx byte),
//               csn_state/csn_rise/csn_fall (chip-select level and edges).
//   User side : tx_data/tx_valid/tx_ready (push), level (occupancy), busy (read streaming).
//   Optional  : underrun, present only when SPI_TX_UNDERRUN_FLAG_EN is defined.
// Modports: slave = the buffer block, master = whatever drives it.
interface spi_dev_txbuf_if #(
  parameter int unsigned DEPTH = 16
);
  logic [7:0]            usr_mosi_data;
  logic                  usr_mosi_stb;
  logic [7:0]            usr_miso_data;
  logic                  usr_miso_ack;
  logic                  csn_state;
  logic                  csn_rise;
  logic                  csn_fall;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [$clog2(DEPTH):0] level;
  logic                  busy;
`ifdef SPI_TX_UNDERRUN_FLAG_EN
  logic                  underrun;
`endif

`ifdef SPI_TX_UNDERRUN_FLAG_EN
  modport slave (
    input  usr_mosi_data, usr_mosi_stb, usr_miso_ack, csn_state, csn_rise, csn_fall,
    input  tx_data, tx_valid,
    output usr_miso_data, tx_ready, level, busy, underrun
  );
  modport master (
    output usr_mosi_data, usr_mosi_stb, usr_miso_ack, csn_state, csn_rise, csn_fall,
    output tx_data, tx_valid,
    input  usr_miso_data, tx_ready, level, busy, underrun
  );
`else
  modport slave (
    input  usr_mosi_data, usr_mosi_stb, usr_miso_ack, csn_state, csn_rise, csn_fall,
    input  tx_data, tx_valid,
    output usr_miso_data, tx_ready, level, busy
  );
  modport master (
    output usr_mosi_data, usr_mosi_stb, usr_miso_ack, csn_state, csn_rise, csn_fall,
    output tx_data, tx_valid,
    input  usr_miso_data, tx_ready, level, busy
  );
`endif

endinterface

// File: rtl/spi_tx_fifo.sv
// Byte FIFO backing the SPI TX buffer.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_push/i_data : push request and byte
//   i_pop         : pop request (ignored when empty)
//   o_full        : occupancy == DEPTH
//   o_level       : current occupancy
//   o_level_next  : occupancy after this cycle's push/pop
//   o_head_next   : head byte after this cycle's push/pop (valid when o_level_next != 0)
// A push while full is accepted only when a pop frees the slot in the same cycle.
module spi_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [7:0]             i_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [$clog2(DEPTH):0] o_level_next,
  output logic [7:0]             o_head_next
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_rptr_next;

  assign o_full    = (r_level == LW'(DEPTH));
  assign w_do_pop  = i_pop & (r_level != '0);
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign w_rptr_next = w_do_pop ? r_rptr + 1'b1 : r_rptr;

  always_comb begin
    o_level_next = r_level;
    unique case ({w_do_push, w_do_pop})
      2'b10:   o_level_next = r_level + 1'b1;
      2'b01:   o_level_next = r_level - 1'b1;
      default: o_level_next = r_level;
    endcase
  end

  // The slot being written this cycle is not in r_mem yet; forward it when it becomes the head.
  assign o_head_next = (w_do_push && (w_rptr_next == r_wptr)) ? i_data : r_mem[w_rptr_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      r_rptr  <= w_rptr_next;
      r_level <= o_level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_level = r_level;

endmodule

// File: rtl/spi_dev_txbuf.sv
// SPI device TX buffer: user logic queues bytes, an SPI host drains them with a read command.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spi_dev_txbuf_if slave (core MOSI/MISO strobes, csn edges, user push, status)
// Behaviour: after csn_fall the first MOSI byte is a command; during it MISO carries the
// FIFO level. READ_CMD streams the FIFO (FILL when empty), anything else is ignored until
// csn_rise. Optional macro SPI_TX_UNDERRUN_FLAG_EN adds a sticky underrun output.
module spi_dev_txbuf
  import spi_proto_defs::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  READ_CMD = CmdReadTxBuf,
  parameter logic [7:0]  FILL     = 8'h00
) (
  input logic             clk,
  input logic             rst,
  spi_dev_txbuf_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  spi_state_e    r_state;
  spi_state_e    w_state_next;
  logic [7:0]    r_miso_data;
  logic [7:0]    w_miso_next;

  logic          w_pop_req;
  logic          w_full;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_next;
  logic [7:0]    w_head_next;

  // Chip-select level is informational only; the edge strobes drive the FSM.
  logic w_unused;
  assign w_unused = bus.csn_state;

  // A byte cut off by csn_rise was never fully shifted out, so it is not consumed.
  assign w_pop_req = (r_state == StStream) & bus.usr_miso_ack & ~bus.csn_rise;

  spi_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (bus.tx_valid),
    .i_data       (bus.tx_data),
    .i_pop        (w_pop_req),
    .o_full       (w_full),
    .o_level      (w_level),
    .o_level_next (w_level_next),
    .o_head_next  (w_head_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_miso_data <= FILL;
    end else begin
      r_state     <= w_state_next;
      r_miso_data <= w_miso_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.csn_rise) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.csn_fall) w_state_next = StCmd;
        end
        StCmd: begin
          if (bus.usr_mosi_stb) begin
            w_state_next = (bus.usr_mosi_data == READ_CMD) ? StStream : StIgnore;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // MISO is computed from next-cycle state so a pop shows the new head one cycle later.
  always_comb begin
    w_miso_next = FILL;
    case (w_state_next)
      StCmd:    w_miso_next = sat_byte(32'(w_level_next));
      StStream: if (w_level_next != '0) w_miso_next = w_head_next;
      default:  w_miso_next = FILL;
    endcase
  end

  assign bus.usr_miso_data = r_miso_data;
  assign bus.tx_ready      = ~w_full;
  assign bus.level         = w_level;
  assign bus.busy          = (r_state == StStream);

`ifdef SPI_TX_UNDERRUN_FLAG_EN
  logic r_underrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if ((w_state_next == StCmd) && (r_state != StCmd)) begin
      r_underrun <= 1'b0;
    end else if (w_pop_req && (w_level == '0)) begin
      r_underrun <= 1'b1;
    end
  end

  assign bus.underrun = r_underrun;
`endif

endmodule

// File: tb/tb_spi_dev_txbuf.sv
module tb_spi_dev_txbuf;

  localparam int unsigned DEPTH    = 16;
  localparam logic [7:0]  READ_CMD = 8'hF5;
  localparam logic [7:0]  FILL     = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_dev_txbuf_if #(.DEPTH(DEPTH)) bus ();

  spi_dev_txbuf #(
    .DEPTH    (DEPTH),
    .READ_CMD (READ_CMD),
    .FILL     (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];     // scoreboard: expected MISO byte per ack
  logic [7:0] model_q[$];   // reference FIFO contents
  bit         model_underrun;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte the core takes is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.usr_miso_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL miso_unexpected: got %0h expected no transfer", bus.usr_miso_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("miso", 32'(bus.usr_miso_data), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic push(input logic [7:0] b);
    bit ready_exp;
    ready_exp   = (model_q.size() < DEPTH);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    check("tx_ready", 32'(bus.tx_ready), 32'(ready_exp));
    tick();
    bus.tx_valid = 1'b0;
    if (ready_exp) model_q.push_back(b);
  endtask

  // One SPI byte: MOSI strobe and MISO ack together, optionally with a user push.
  task automatic xfer(input logic [7:0] mosi, input bit with_push, input logic [7:0] pbyte,
                      input logic [7:0] exp, input bit ready_exp);
    exp_q.push_back(exp);
    bus.usr_mosi_data = mosi;
    bus.usr_mosi_stb  = 1'b1;
    bus.usr_miso_ack  = 1'b1;
    if (with_push) begin
      bus.tx_data  = pbyte;
      bus.tx_valid = 1'b1;
      check("tx_ready_xfer", 32'(bus.tx_ready), 32'(ready_exp));
    end
    tick();
    bus.usr_mosi_stb = 1'b0;
    bus.usr_miso_ack = 1'b0;
    bus.tx_valid     = 1'b0;
    tick();
  endtask

  task automatic csn_fall();
    bus.csn_state = 1'b0;
    bus.csn_fall  = 1'b1;
    tick();
    bus.csn_fall   = 1'b0;
    model_underrun = 1'b0;
    tick();
  endtask

  task automatic csn_rise();
    bus.csn_state = 1'b1;
    bus.csn_rise  = 1'b1;
    tick();
    bus.csn_rise = 1'b0;
    tick();
  endtask

  task automatic transaction(input logic [7:0] cmd, input int n, input bit push_each);
    bit         rd;
    bit         popping;
    bit         ready_exp;
    logic [7:0] e;
    logic [7:0] pb;
    rd = (cmd == READ_CMD);
    csn_fall();
    xfer(cmd, 1'b0, 8'h00, sat8(model_q.size()), 1'b1);
    check("busy_after_cmd", 32'(bus.busy), 32'(rd));
    for (int i = 0; i < n; i++) begin
      pb        = 8'($urandom);
      ready_exp = (model_q.size() < DEPTH);
      popping   = rd && (model_q.size() > 0);
      if (popping) begin
        e = model_q.pop_front();
      end else begin
        e = FILL;
        if (rd) model_underrun = 1'b1;
      end
      xfer(8'($urandom), push_each, pb, e, ready_exp);
      if (push_each && (ready_exp || popping)) model_q.push_back(pb);
    end
    csn_rise();
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("level", 32'(bus.level), 32'(model_q.size()));
`ifdef SPI_TX_UNDERRUN_FLAG_EN
    check("underrun", 32'(bus.underrun), 32'(model_underrun));
`endif
  endtask

  initial begin
    logic [7:0] rcmd;
    bus.usr_mosi_data = 8'h00;
    bus.usr_mosi_stb  = 1'b0;
    bus.usr_miso_ack  = 1'b0;
    bus.csn_state     = 1'b1;
    bus.csn_rise      = 1'b0;
    bus.csn_fall      = 1'b0;
    bus.tx_data       = 8'h00;
    bus.tx_valid      = 1'b0;
    model_underrun    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_miso", 32'(bus.usr_miso_data), 32'(FILL));
    check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SPI_TX_UNDERRUN_FLAG_EN
    check("rst_underrun", 32'(bus.underrun), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic read: 03, A1, B2, C3.
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    transaction(READ_CMD, 3, 1'b0);

    // Empty read: all FILL, underrun.
    transaction(READ_CMD, 2, 1'b0);

    // Non-read command: level reported then FILL, nothing popped.
    for (int i = 0; i < 5; i++) push(8'($urandom));
    transaction(8'h12, 4, 1'b0);
    transaction(READ_CMD, 5, 1'b0);

    // Overfill: last two dropped, full read returns first DEPTH in order.
    for (int i = 0; i < DEPTH + 2; i++) push(8'(i + 8'h40));
    check("level_full", 32'(bus.level), 32'(DEPTH));
    transaction(READ_CMD, DEPTH, 1'b0);

    // Partial read; remainder kept for the next read.
    for (int i = 0; i < 4; i++) push(8'(i + 8'h70));
    transaction(READ_CMD, 2, 1'b0);
    transaction(READ_CMD, 2, 1'b0);

    // Push+pop while full keeps level at DEPTH; then drain to verify order.
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    transaction(READ_CMD, 3, 1'b1);
    check("level_full_pp", 32'(bus.level), 32'(DEPTH));
    transaction(READ_CMD, DEPTH + 1, 1'b0);

    // Push+pop while empty: FILL sent, push kept.
    transaction(READ_CMD, 1, 1'b1);
    transaction(READ_CMD, 1, 1'b0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) push(8'(i + 8'h90));
    csn_fall();
    xfer(READ_CMD, 1'b0, 8'h00, sat8(model_q.size()), 1'b1);
    xfer(8'h00, 1'b0, 8'h00, model_q.pop_front(), 1'b1);
    rst = 1'b1;
    #2;
    model_q.delete();
    model_underrun = 1'b0;
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_miso", 32'(bus.usr_miso_data), 32'(FILL));
    check("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(8'h11);
    push(8'h22);
    // csn still low, but no fresh csn_fall: acks (even with READ_CMD) pop nothing.
    xfer(READ_CMD, 1'b0, 8'h00, FILL, 1'b1);
    xfer(8'h33, 1'b0, 8'h00, FILL, 1'b1);
    check("midrst_nopop", 32'(bus.level), 32'd2);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    csn_rise();
    transaction(READ_CMD, 2, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < int'($urandom_range(0, 7)); p++) push(8'($urandom));
      rcmd = ($urandom_range(0, 2) != 0) ? READ_CMD : 8'($urandom);
      transaction(rcmd, int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    end

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
